wm8731_i2c_responder: RTL and testbench
=======================================

WM8731_I2C_RESPONDER -- requirements
Module: wm8731_i2c_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit I2C device address the block answers to.
REQ-002 Parameter NUM_REGS, default 10, number of implemented control registers, indices 0..9.
REQ-003 clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i2c_sclk  input  1  I2C clock from the master, asynchronous to clk.
REQ-006 i2c_sdat_in  input  1  sampled level of the open-drain SDA line.
REQ-007 i2c_sdat_oe  output  1  1 = pull SDA low, 0 = release.
REQ-008 rd_index  input  4  register index for the read-back port.
REQ-009 rd_data  output  9  combinational value of register rd_index; 9'h000 when rd_index >= NUM_REGS.
REQ-010 wr_pulse  output  1  one-clk strobe when a register write commits.
REQ-011 wr_addr  output  7  register address of the last committed write.
REQ-012 wr_data  output  9  data of the last committed write.
REQ-013 bad_reg  output  1  one-clk strobe when a frame targets an unimplemented address.

Function
REQ-014 i2c_sclk and i2c_sdat_in pass through 2-flop synchronizers; edge detection uses the synchronized values.
REQ-015 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high.
REQ-016 Data bits are sampled on the synchronized SCL rising edge, MSB first.
REQ-017 States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
REQ-018 START from any state enters ADDR and clears the bit counter; this covers repeated START.
REQ-019 STOP from any state enters IDLE; a frame cut short before the 16th data bit commits nothing.
REQ-020 ADDR collects 8 bits; a match on {DEV_ADDR, 0} goes to ACK_A; anything else, including R/W=1, goes to IGNORE with no ACK.
REQ-021 ACK rule: i2c_sdat_oe asserts on the SCL falling edge after the 8th bit and releases on the next SCL falling edge.
REQ-022 ACK_A leads to BYTE1; ACK_1 leads to BYTE2; ACK_2 leads to IGNORE.
REQ-023 BYTE1 carries the register address in bits [7:1] and data bit 8 in bit 0; BYTE2 carries data bits [7:0].
REQ-024 Commit happens 1 clk after the synchronized SCL rise sampling the last BYTE2 bit.
REQ-025 At commit: wr_pulse=1 for 1 clk, wr_addr and wr_data update, and register[addr] loads the data if addr < NUM_REGS.
REQ-026 A commit to address 7'h0F with any data loads all registers with their defaults in the same clk; the wr_pulse rule of REQ-025 still applies.
REQ-027 A commit to any other address >= NUM_REGS changes no register and pulses bad_reg with wr_pulse.
REQ-028 Every data byte is ACKed regardless of address validity.
REQ-029 Any byte after BYTE2 is not ACKed; the block stays in IGNORE until START or STOP.
REQ-030 i2c_sdat_oe is 0 in every state except the ACK windows of REQ-021.
REQ-031 Register defaults, indices 0..9: 097, 097, 079, 079, 00A, 008, 09F, 00A, 000, 000 (hex).

Reset
REQ-032 Reset (asynchronous, active-high) applies the following: state=IDLE, i2c_sdat_oe=0, wr_pulse=0, bad_reg=0, wr_addr=0, wr_data=0, registers=defaults, synchronizers=1 (idle bus).
REQ-033 Reset asserted mid-frame releases SDA immediately and discards the partial frame.
REQ-034 After reset the block ignores bus activity until a new START.

Verification
REQ-035 Write 0x34, 0x08, 0x12 (R4 = 0x012) -> three ACKs, one wr_pulse, wr_addr=0x04, wr_data=0x012, rd_data(4)=0x012.
REQ-036 Address byte 0x36 or 0x35 -> no ACK, no wr_pulse, registers unchanged until STOP.
REQ-037 Write 0x34, 0x0D, 0xFF (R6 = 0x1FF), then 0x34, 0x1E, 0x00 (R15 reset) -> rd_data(6) reads 0x1FF, then 0x09F after the second commit.
REQ-038 Write 0x34, 0x14 (addr 0x0A), 0x00 -> both data bytes ACKed, wr_pulse and bad_reg in the same clk, no register changed.
REQ-039 STOP after BYTE1, and separately reset asserted during BYTE2 -> no commit, SDA released, the next full frame commits correctly.
REQ-040 Repeated START after ACK_1, then a full valid frame -> only the second frame commits; a fourth data byte is NACKed.

Source files
------------

// File: rtl/wm8731_i2c_responder.sv
// ---------------------------------------------------------------------------
// wm8731_i2c_responder
//
// Write-only I2C target that models the WM8731 codec control port. A frame is
// START, address byte {DEV_ADDR, W}, two data bytes, STOP. Byte 1 carries the
// 7-bit register address plus data bit 8, byte 2 carries data bits 7..0.
// Bus lines are treated as asynchronous and are oversampled with clk.
//
// Ports
//   clk          system clock (50 MHz), the only clock
//   reset        asynchronous, active-high reset
//   i2c_sclk     SCL from the master
//   i2c_sdat_in  sampled level of the open-drain SDA line
//   i2c_sdat_oe  1 = pull SDA low (ACK), 0 = release
//   rd_index     register index for the read-back port
//   rd_data      value of register rd_index, 0 when the index is unimplemented
//   wr_pulse     one-clk strobe when a register write commits
//   wr_addr      register address of the last committed write
//   wr_data      data of the last committed write
//   bad_reg      one-clk strobe, with wr_pulse, for an unimplemented address
// ---------------------------------------------------------------------------
module wm8731_i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    input  logic [3:0] rd_index,
    output logic [8:0] rd_data,
    output logic       wr_pulse,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       bad_reg
);

    // Writing this address restores every register to its default value.
    localparam logic [6:0] RESET_ADDR = 7'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_BYTE1,
        ST_ACK_1,
        ST_BYTE2,
        ST_ACK_2,
        ST_IGNORE
    } state_t;

    function automatic logic [8:0] f_default(input int idx);
        case (idx)
            0:       return 9'h097;
            1:       return 9'h097;
            2:       return 9'h079;
            3:       return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Bus synchronizers and edge detection
    // -----------------------------------------------------------------------
    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    // Synchronizers reset to 1 so that a reset looks like an idle bus and
    // produces no false edge or START when it is released.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= i2c_sclk;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i2c_sdat_in;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    // SDA may only change while SCL is low; a change with SCL held high on
    // both samples is a START (falling) or STOP (rising) condition.
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte1;
    logic       r_sdat_oe;
    logic       r_commit;
    logic [6:0] r_cmt_addr;
    logic [8:0] r_cmt_data;

    logic [7:0] w_next_byte;
    state_t     w_ack_next;

    // Byte as it stands once the bit sampled on this SCL rise is shifted in.
    assign w_next_byte = {r_shift[6:0], r_sda_sync};

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_ack_next = ST_IGNORE;
        case (r_state)
            ST_ACK_A: w_ack_next = ST_BYTE1;
            ST_ACK_1: w_ack_next = ST_BYTE2;
            default:  w_ack_next = ST_IGNORE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_byte1    <= 8'h00;
            r_sdat_oe  <= 1'b0;
            r_commit   <= 1'b0;
            r_cmt_addr <= 7'h00;
            r_cmt_data <= 9'h000;
        end else begin
            r_commit <= 1'b0;
            if (w_start) begin
                // Also covers repeated START in the middle of a frame.
                r_state   <= ST_ADDR;
                r_bit_cnt <= 3'd0;
                r_sdat_oe <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_sdat_oe <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_next_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                // Only a write to our address is acknowledged.
                                r_state <= (w_next_byte == {DEV_ADDR, 1'b0}) ? ST_ACK_A
                                                                             : ST_IGNORE;
                            end
                        end
                    end

                    ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
                        // First SCL fall after the 8th bit pulls SDA low for
                        // the 9th clock; the next fall releases it.
                        if (w_scl_fall) begin
                            if (!r_sdat_oe) begin
                                r_sdat_oe <= 1'b1;
                            end else begin
                                r_sdat_oe <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= w_ack_next;
                            end
                        end
                    end

                    ST_BYTE1: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_next_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_byte1 <= w_next_byte;
                                r_state <= ST_ACK_1;
                            end
                        end
                    end

                    ST_BYTE2: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_next_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                // 16th data bit received: the write is now
                                // complete even if STOP follows at once.
                                r_commit   <= 1'b1;
                                r_cmt_addr <= r_byte1[7:1];
                                r_cmt_data <= {r_byte1[0], w_next_byte};
                                r_state    <= ST_ACK_2;
                            end
                        end
                    end

                    default: begin
                        // IDLE and IGNORE wait for START or STOP only.
                    end
                endcase
            end
        end
    end

    assign i2c_sdat_oe = r_sdat_oe;

    // -----------------------------------------------------------------------
    // Register file and commit strobes
    // -----------------------------------------------------------------------
    logic [8:0] r_regs [NUM_REGS];

    // NOTE: the register file is reset because its defaults are architectural
    // (readable straight after reset); large RAM-style arrays would not be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pulse <= 1'b0;
            bad_reg  <= 1'b0;
            wr_addr  <= 7'h00;
            wr_data  <= 9'h000;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= f_default(i);
            end
        end else begin
            wr_pulse <= r_commit;
            bad_reg  <= 1'b0;
            if (r_commit) begin
                wr_addr <= r_cmt_addr;
                wr_data <= r_cmt_data;
                if (r_cmt_addr == RESET_ADDR) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        r_regs[i] <= f_default(i);
                    end
                end else if (int'(r_cmt_addr) >= NUM_REGS) begin
                    bad_reg <= 1'b1;
                end else begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (int'(r_cmt_addr) == i) begin
                            r_regs[i] <= r_cmt_data;
                        end
                    end
                end
            end
        end
    end

    // Read-back mux; unimplemented indices read as zero.
    always_comb begin
        rd_data = 9'h000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_index) == i) begin
                rd_data = r_regs[i];
            end
        end
    end

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// ---------------------------------------------------------------------------
// Directed bench for wm8731_i2c_responder. An I2C master is modelled with
// tasks; SDA is the wired-AND of the master's drive and the DUT's pull-down.
// ---------------------------------------------------------------------------
module tb_wm8731_i2c_responder;

    localparam int Q = 20;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       i2c_sdat_oe;
    logic [3:0] rd_index;
    logic [8:0] rd_data;
    logic       wr_pulse;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       bad_reg;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int bad_cnt = 0;
    int both_cnt = 0;

    logic [8:0] defs [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                              9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

    assign sda_line = sda_m & ~i2c_sdat_oe;

    always #10 clk = ~clk;

    wm8731_i2c_responder #(
        .DEV_ADDR (7'h1A),
        .NUM_REGS (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i2c_sclk    (scl),
        .i2c_sdat_in (sda_line),
        .i2c_sdat_oe (i2c_sdat_oe),
        .rd_index    (rd_index),
        .rd_data     (rd_data),
        .wr_pulse    (wr_pulse),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bad_reg     (bad_reg)
    );

    // Count strobe cycles; a one-clk strobe adds exactly one per commit.
    always @(posedge clk) begin
        if (wr_pulse === 1'b1) pulse_cnt++;
        if (bad_reg === 1'b1) bad_cnt++;
        if (wr_pulse === 1'b1 && bad_reg === 1'b1) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input int idx, input logic [8:0] exp);
        rd_index = 4'(idx);
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic i2c_start();
        if (scl == 1'b0) begin
            sda_m = 1'b1; tick(Q);
            scl   = 1'b1; tick(Q);
        end
        sda_m = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7 - i]; tick(Q);
            scl   = 1'b1;     tick(2 * Q);
            scl   = 1'b0;     tick(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output int ack);
        send_bits(b, 8);
        sda_m = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        ack   = (sda_line === 1'b0) ? 1 : 0;
        tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic write_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, output int acks);
        int a;
        acks = 0;
        i2c_start();
        write_byte(b0, a); acks += a;
        write_byte(b1, a); acks += a;
        write_byte(b2, a); acks += a;
        i2c_stop();
    endtask

    task automatic bus_idle_reset();
        reset = 1'b1;
        tick(2);
        scl   = 1'b1; tick(2);
        sda_m = 1'b1; tick(Q);
        reset = 1'b0; tick(Q);
    endtask

    initial begin
        int acks;
        int a;
        int p0;
        int b0;
        int x0;

        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; rd_index = 4'd0;
        tick(5);
        reset = 1'b0;
        tick(5);

        // Reset state
        check("rst_oe", 32'(i2c_sdat_oe), 0);
        check("rst_wr_pulse", 32'(wr_pulse), 0);
        check("rst_bad_reg", 32'(bad_reg), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        for (int i = 0; i < 10; i++) rd_check("rst_rd_default", i, defs[i]);
        rd_check("rst_rd_idx10", 10, 9'h000);
        rd_check("rst_rd_idx15", 15, 9'h000);

        // Basic write R4 = 0x012
        p0 = pulse_cnt; b0 = bad_cnt;
        write_frame(8'h34, 8'h08, 8'h12, acks);
        check("w4_acks", 32'(acks), 3);
        check("w4_pulses", 32'(pulse_cnt - p0), 1);
        check("w4_bad", 32'(bad_cnt - b0), 0);
        check("w4_wr_addr", 32'(wr_addr), 32'h04);
        check("w4_wr_data", 32'(wr_data), 32'h012);
        rd_check("w4_rd4", 4, 9'h012);
        check("w4_oe_idle", 32'(i2c_sdat_oe), 0);

        // Wrong address and read bit: nothing acknowledged or written
        p0 = pulse_cnt;
        write_frame(8'h36, 8'h0A, 8'h55, acks);
        check("addr36_acks", 32'(acks), 0);
        write_frame(8'h35, 8'h0A, 8'h55, acks);
        check("addr35_acks", 32'(acks), 0);
        check("badaddr_pulses", 32'(pulse_cnt - p0), 0);
        rd_check("badaddr_rd5", 5, 9'h008);
        check("badaddr_wr_addr", 32'(wr_addr), 32'h04);

        // R6 = 0x1FF, then register reset via address 0x0F
        p0 = pulse_cnt; b0 = bad_cnt;
        write_frame(8'h34, 8'h0D, 8'hFF, acks);
        check("w6_acks", 32'(acks), 3);
        rd_check("w6_rd6", 6, 9'h1FF);
        check("w6_wr_data", 32'(wr_data), 32'h1FF);
        write_frame(8'h34, 8'h1E, 8'h00, acks);
        check("r15_acks", 32'(acks), 3);
        check("r15_pulses", 32'(pulse_cnt - p0), 2);
        check("r15_bad", 32'(bad_cnt - b0), 0);
        check("r15_wr_addr", 32'(wr_addr), 32'h0F);
        rd_check("r15_rd6", 6, 9'h09F);
        rd_check("r15_rd4", 4, 9'h00A);

        // Unimplemented address 0x0A: ACKed, bad_reg with wr_pulse
        p0 = pulse_cnt; b0 = bad_cnt; x0 = both_cnt;
        write_frame(8'h34, 8'h14, 8'h00, acks);
        check("bad_acks", 32'(acks), 3);
        check("bad_pulses", 32'(pulse_cnt - p0), 1);
        check("bad_strobes", 32'(bad_cnt - b0), 1);
        check("bad_same_clk", 32'(both_cnt - x0), 1);
        check("bad_wr_addr", 32'(wr_addr), 32'h0A);
        for (int i = 0; i < 10; i++) rd_check("bad_rd_unchanged", i, defs[i]);

        // STOP after BYTE1: no commit, then a full frame R5 = 0x134
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h34, a);
        write_byte(8'h08, a);
        i2c_stop();
        check("stop_b1_pulses", 32'(pulse_cnt - p0), 0);
        check("stop_b1_oe", 32'(i2c_sdat_oe), 0);
        write_frame(8'h34, 8'h0B, 8'h34, acks);
        check("w5_acks", 32'(acks), 3);
        check("w5_pulses", 32'(pulse_cnt - p0), 1);
        rd_check("w5_rd5", 5, 9'h134);
        rd_check("w5_rd4", 4, 9'h00A);

        // Reset during the address ACK window releases SDA at once
        i2c_start();
        send_bits(8'h34, 8);
        check("ack_window_oe", 32'(i2c_sdat_oe), 1);
        reset = 1'b1;
        #1;
        check("rst_ack_oe", 32'(i2c_sdat_oe), 0);
        bus_idle_reset();

        // Reset during BYTE2: no commit, registers back to defaults
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h34, a);
        write_byte(8'h08, a);
        send_bits(8'h99, 4);
        reset = 1'b1;
        #1;
        check("rst_b2_oe", 32'(i2c_sdat_oe), 0);
        bus_idle_reset();
        check("rst_b2_pulses", 32'(pulse_cnt - p0), 0);
        rd_check("rst_b2_rd5", 5, 9'h008);
        rd_check("rst_b2_rd4", 4, 9'h00A);
        write_frame(8'h34, 8'h08, 8'h55, acks);
        check("post_rst_acks", 32'(acks), 3);
        check("post_rst_pulses", 32'(pulse_cnt - p0), 1);
        rd_check("post_rst_rd4", 4, 9'h055);

        // Repeated START after ACK_1, full frame, then NACKed fourth byte
        p0 = pulse_cnt;
        acks = 0;
        i2c_start();
        write_byte(8'h34, a); acks += a;
        write_byte(8'h0C, a); acks += a;
        i2c_start();
        write_byte(8'h34, a); acks += a;
        write_byte(8'h0E, a); acks += a;
        write_byte(8'h21, a); acks += a;
        write_byte(8'h77, a);
        check("rs_fourth_nack", 32'(a), 0);
        i2c_stop();
        check("rs_acks", 32'(acks), 5);
        check("rs_pulses", 32'(pulse_cnt - p0), 1);
        check("rs_wr_addr", 32'(wr_addr), 32'h07);
        check("rs_wr_data", 32'(wr_data), 32'h021);
        rd_check("rs_rd7", 7, 9'h021);
        rd_check("rs_rd6", 6, 9'h09F);
        check("rs_oe_idle", 32'(i2c_sdat_oe), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
